// File: rtl/dotstar_string_driver.sv
// rtl/dotstar_string_driver.sv - APA102/DotStar string serialiser pulling RGB pixels over valid/ready
// Optional build macro: DOTSTAR_GAMMA_EN squares each colour byte ((c*c)>>8) when the pixel is latched.
module dotstar_string_driver #(
    parameter int NUM_LEDS  = 60,
    parameter int SCK_DIV   = 4,
    parameter int FRAME_GAP = 16,
    parameter int IDX_W     = 12
) (
    input  logic             dostring_clk,
    input  logic             my_reset_n,
    input  logic             start,
    input  logic             cont,
    input  logic [4:0]       brightness,
    input  logic             pix_valid,
    input  logic [23:0]      pix_data,
    output logic             pix_ready,
    output logic [IDX_W-1:0] pix_index,
    output logic             mosi,
    output logic             sck,
    output logic             busy,
    output logic             frame_done,
    output logic             led1,
    output logic             led2
);
    localparam int END_RAW  = 8 * ((NUM_LEDS + 15) / 16);
    localparam int END_BITS = (END_RAW > 32) ? END_RAW : 32;
    localparam int DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_FETCH, S_PIXEL, S_END, S_DONE, S_GAP} state_t;

    state_t           r_state;
    logic [31:0]      r_shift;
    logic [15:0]      r_bits_left;
    logic [DIV_W-1:0] r_div;
    logic [GAP_W-1:0] r_gap;
    logic [4:0]       r_bright;
    logic [IDX_W-1:0] r_index;
    logic             r_sck;
    logic             r_busy;
    logic             r_pix_ready;
    logic             r_done;
    logic             r_led2;
    logic [31:0]      w_word;
    logic             w_launch;

    function automatic logic [7:0] f_color(input logic [7:0] c);
`ifdef DOTSTAR_GAMMA_EN
        return 8'(({8'd0, c} * {8'd0, c}) >> 8);
`else
        return c;
`endif
    endfunction

    // Wire order on the string is B, G, R after the brightness header.
    assign w_word = {3'b111, r_bright, f_color(pix_data[7:0]),
                     f_color(pix_data[15:8]), f_color(pix_data[23:16])};

    always_comb begin
        w_launch = 1'b0;
        case (r_state)
            S_IDLE:  w_launch = start || cont;
            S_DONE:  w_launch = cont && (FRAME_GAP == 0);
            S_GAP:   w_launch = cont && (r_gap == GAP_LAST);
            default: w_launch = 1'b0;
        endcase
    end

    always_ff @(posedge dostring_clk or negedge my_reset_n) begin
        if (!my_reset_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_div       <= '0;
            r_gap       <= '0;
            r_bright    <= '0;
            r_index     <= '0;
            r_sck       <= 1'b0;
            r_busy      <= 1'b0;
            r_pix_ready <= 1'b0;
            r_done      <= 1'b0;
            r_led2      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                end
                S_START, S_PIXEL, S_END: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        r_sck <= ~r_sck;
                        // A bit ends on the falling sck edge; mosi moves only then.
                        if (r_sck) begin
                            if (r_bits_left != 16'd1) begin
                                r_bits_left <= r_bits_left - 16'd1;
                                r_shift     <= {r_shift[30:0], r_state == S_END};
                            end else if (r_state == S_START) begin
                                r_state     <= S_FETCH;
                                r_pix_ready <= 1'b1;
                            end else if (r_state == S_PIXEL && r_index != IDX_LAST) begin
                                r_index     <= r_index + 1'b1;
                                r_state     <= S_FETCH;
                                r_pix_ready <= 1'b1;
                            end else if (r_state == S_PIXEL) begin
                                r_state     <= S_END;
                                r_shift     <= '1;
                                r_bits_left <= 16'(END_BITS);
                            end else begin
                                r_state <= S_DONE;
                                r_shift <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_led2  <= ~r_led2;
                            end
                        end
                    end
                end
                S_FETCH: begin
                    if (pix_valid) begin
                        r_pix_ready <= 1'b0;
                        r_shift     <= w_word;
                        r_bits_left <= 16'd32;
                        r_state     <= S_PIXEL;
                    end
                end
                S_DONE: begin
                    r_gap   <= '0;
                    r_state <= cont ? S_GAP : S_IDLE;
                end
                S_GAP: begin
                    if (!cont) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_launch) begin
                r_state     <= S_START;
                r_bright    <= brightness;
                r_index     <= '0;
                r_busy      <= 1'b1;
                r_shift     <= '0;
                r_bits_left <= 16'd32;
                r_div       <= '0;
                r_sck       <= 1'b0;
            end
        end
    end

    assign pix_ready  = r_pix_ready;
    assign pix_index  = r_index;
    assign mosi       = r_shift[31];
    assign sck        = r_sck;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign led1       = r_busy;
    assign led2       = r_led2;
endmodule
